idli_uart_tx: RTL

IDLI_UART_TX -- requirements
Module: idli_uart_tx

---
 rtl/idli_uart_tx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/idli_uart_tx.sv
// idli_uart_tx: nibble-serial write port feeding a 16-bit UART transmitter.
//
// A 16-bit word arrives as four 4-bit slices over four consecutive cycles. The
// slice index comes from the core cycle counter. A complete word lands in a
// single-entry holding register. The transmitter copies that register into a
// shift register and sends it as two 8N1 frames, low byte first, with no gap
// between them.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit period (2..65535)
//
// Ports
//   i_clk     : clock, all state updates on the rising edge
//   i_rst     : synchronous active-high reset
//   i_wr_vld  : write slice present this cycle
//   i_wr_data : 4-bit write slice, least significant slice first
//   i_ctr     : core cycle counter, slice index 0..3
//   o_busy    : holding register full, a new write would be dropped
//   o_active  : transmitter is sending (START, DATA or STOP)
//   o_ovf     : one-cycle pulse, a write was dropped
//   o_tx      : UART serial line, idle high

module idli_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr_vld,
   input  logic [3:0] i_wr_data,
   input  logic [1:0] i_ctr,
   output logic       o_busy,
   output logic       o_active,
   output logic       o_ovf,
   output logic       o_tx
);

   localparam int unsigned     CntW   = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   // Transmitter state
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            byte_sel_q, byte_sel_d;
   logic [15:0]     shift_q, shift_d;

   // Holding register and write sequencing
   logic [15:0]     hold_q, hold_d;
   logic            hold_vld_q, hold_vld_d;
   logic            wr_open_q, wr_open_d;
   logic [1:0]      wr_ctr_q, wr_ctr_d;
   logic            ovf_q, ovf_d;

   logic            wr_done;
   logic            load;
   logic            bit_end;

   assign bit_end = (cnt_q == CntMax);

   // -------------------------------------------------------------------------
   // Write sequencing
   // -------------------------------------------------------------------------
   // Slices are written straight into the holding register. That is safe
   // because a write can only open while hold_vld is clear, so the transmitter
   // never reads a half-written word. A slice 0 always starts a new write,
   // even if another write is still open.
   always_comb begin
      hold_d    = hold_q;
      wr_open_d = wr_open_q;
      wr_ctr_d  = wr_ctr_q;
      ovf_d     = 1'b0;
      wr_done   = 1'b0;

      if (i_wr_vld && (i_ctr == 2'd0)) begin
         if (hold_vld_q) begin
            // Holding register still full: drop the whole write.
            ovf_d     = 1'b1;
            wr_open_d = 1'b0;
         end else begin
            hold_d[3:0] = i_wr_data;
            wr_open_d   = 1'b1;
            wr_ctr_d    = 2'd1;
         end
      end else if (wr_open_q) begin
         if (i_wr_vld && (i_ctr == wr_ctr_q)) begin
            case (i_ctr)
               2'd1:    hold_d[7:4]   = i_wr_data;
               2'd2:    hold_d[11:8]  = i_wr_data;
               2'd3:    hold_d[15:12] = i_wr_data;
               default: hold_d[3:0]   = i_wr_data;
            endcase
            if (i_ctr == 2'd3) begin
               wr_done   = 1'b1;
               wr_open_d = 1'b0;
            end else begin
               wr_ctr_d = wr_ctr_q + 2'd1;
            end
         end else begin
            // Gap or out-of-order slice: abandon without publishing.
            wr_open_d = 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Transmitter FSM
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_sel_d = byte_sel_q;
      shift_d    = shift_q;
      load       = 1'b0;

      case (state_q)
         StIdle: begin
            if (hold_vld_q) begin
               load       = 1'b1;
               shift_d    = hold_q;
               byte_sel_d = 1'b0;
               cnt_d      = '0;
               bit_idx_d  = '0;
               state_d    = StStart;
            end
         end

         StStart: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StData: begin
            if (bit_end) begin
               cnt_d = '0;
               // After eight shifts of the low byte, shift_q[7:0] holds the high byte.
               shift_d = {1'b0, shift_q[15:1]};
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StStop: begin
            if (bit_end) begin
               cnt_d = '0;
               if (!byte_sel_q) begin
                  byte_sel_d = 1'b1;
                  state_d    = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // A load and a write completion never happen in the same cycle: a
   // completing write opened with hold_vld clear, and a load needs it set.
   always_comb begin
      hold_vld_d = hold_vld_q;
      if (load) begin
         hold_vld_d = 1'b0;
      end
      if (wr_done) begin
         hold_vld_d = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         byte_sel_q <= 1'b0;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         wr_open_q  <= 1'b0;
         wr_ctr_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_sel_q <= byte_sel_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         wr_open_q  <= wr_open_d;
         wr_ctr_q   <= wr_ctr_d;
         ovf_q      <= ovf_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      case (state_q)
         StStart: o_tx = 1'b0;
         StData:  o_tx = shift_q[0];
         default: o_tx = 1'b1;
      endcase
   end

   assign o_active = (state_q != StIdle);
   assign o_busy   = hold_vld_q;
   assign o_ovf    = ovf_q;

endmodule
